eq_coeff_scheduler: RTL
=======================

# eq_coeff_scheduler

Coefficient controller for the cascaded three-band biquad equalizer. Accepts coefficient writes from the MCU interface into a shadow bank. On a commit request, it copies the whole shadow bank into the active bank on the next `l_r_clk` edge. The filters therefore never run a sample with a mix of old and new coefficients. The active-bank outputs drive the `low_*`, `mid_*` and `high_*` coefficient inputs of the equalizer directly.

## Interface
Parameters:
- `NUM_COEF`, default 15: total number of coefficients, 3 bands × {b0,b1,b2,a1,a2}.
- `COEF_W`, default 16: coefficient width, signed Q2.14.

Ports:
- `clk`  in  1: system clock. One clock only. Reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high; acts on a `clk` edge.
- `l_r_clk`  in  1: left/right select. Each edge starts a new sample.
- `wr_valid`  in  1: coefficient write request.
- `wr_ready`  out  1: write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  4: coefficient index = band*5 + coef. Band: 0 = low, 1 = mid, 2 = high. Coef: 0..4 = b0, b1, b2, a1, a2.
- `wr_data`  in  16: signed Q2.14 coefficient value.
- `commit`  in  1: one-cycle pulse requesting a swap of shadow into active.
- `pending`  out  1: a commit is armed and waiting for an `l_r_clk` edge.
- `swap_done`  out  1: one-cycle pulse in the cycle after the active bank updates.
- `addr_err`  out  1: one-cycle pulse when a write is accepted with `wr_addr` ≥ 15.
- `low_b0, low_b1, low_b2, low_a1, low_a2`  out  16 each: active low-band coefficients.
- `mid_b0 … mid_a2`  out  16 each: active mid-band coefficients.
- `high_b0 … high_a2`  out  16 each: active high-band coefficients.

## Operation
- States are IDLE and PENDING.
- **IDLE**
  - `wr_ready` = 1.
  - An accepted write with `wr_addr` < 15 updates `shadow[wr_addr]`. With `wr_addr` ≥ 15 the data is dropped and `addr_err` pulses.
  - `commit` = 1 moves the state to PENDING.
- **PENDING**
  - `wr_ready` = 0, so the shadow bank is frozen. `pending` = 1.
  - Further `commit` pulses are ignored.
  - On the first `clk` edge where `edge_det` = 1: `active <= shadow`, state goes to IDLE, and `swap_done` is registered high for one cycle.
- Edge detection:
  - `l_r_clk_prev` is registered every cycle.
  - `edge_det = (l_r_clk != l_r_clk_prev)`.
  - Both rising and falling edges count.
- A `commit` and a write in the same IDLE cycle: the write lands in shadow first, and that value is included in the swap.
- A `commit` in a cycle where `edge_det` = 1 while IDLE: the swap is not immediate. It waits for the next `l_r_clk` edge.
- The active bank is registered and changes only on a swap or on reset. The shadow bank holds its value after a swap.
- No arithmetic is performed. Coefficients pass through bit-exact.

## Timing
- Reset values:
  - State = IDLE.
  - Both banks: every b0 = 16'sh4000 (unity), all other coefficients 0. The filters are therefore pass-through.
  - `wr_ready` = 1; `pending`, `swap_done`, `addr_err` = 0; `l_r_clk_prev` = 0.
- Write latency: 1 cycle from acceptance to the shadow update.
- `commit` to `pending` = 1: 1 cycle.
- Swap latency: active outputs change at the `clk` edge where `edge_det` is first true after PENDING is entered. `swap_done` is high the following cycle.
- Worst-case `pending` duration: one `l_r_clk` half-period plus 1 cycle.
- Reset asserted during PENDING: the armed commit is discarded and both banks return to defaults. No `swap_done` pulse is produced.

## Configuration
- `EQ_COEFF_READBACK_EN` defined:
  - Adds ports `rd_addr` (in 4) and `rd_data` (out 16).
  - `rd_data` is registered, 1-cycle latency, and returns `active[rd_addr]`.
  - For `rd_addr` ≥ 15, `rd_data` = 0. `rd_data` resets to 0.
- Macro not defined: the readback ports and logic are absent. All other behaviour is identical.

## Structure
- Package `eq_pkg` holds:
  - `NUM_COEF = 15`, `COEFS_PER_BAND = 5`, `COEF_UNITY = 16'sh4000`.
  - `typedef logic signed [15:0] coef_t`.
  - Enum `coef_sel_e` {B0, B1, B2, A1, A2}.
  - Enum `band_e` {LOW, MID, HIGH}.
  - State enum `sched_state_e` {IDLE, PENDING}.
- One sub-module, `lr_edge_detect`: registers `l_r_clk_prev` and produces `edge_det`. It shares the same `clk` and `reset`.

## Test plan
- Reset, then read the outputs → `low_b0` = `mid_b0` = `high_b0` = 16'sh4000, all others 0, `wr_ready` = 1, `pending` = 0.
- Write addr 0 = 16'sh1234 and addr 14 = 16'shC000 with no commit, then toggle `l_r_clk` twice → active outputs unchanged.
- Commit, then toggle `l_r_clk` 20 cycles later → `pending` is high for 20 cycles, then `low_b0` = 16'sh1234 and `high_a2` = 16'shC000 at the edge, and `swap_done` pulses exactly once.
- While PENDING, drive `wr_valid` with addr 5 = 16'sh7FFF → `wr_ready` = 0, the write stalls, and it lands in shadow after the swap, with active `mid_b0` still at its old value.
- Write addr 15 → `addr_err` pulses, and neither bank changes.
- Commit, then assert `reset` before any `l_r_clk` edge → defaults restored, `pending` = 0, no `swap_done`.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared definitions for the three-band equalizer coefficient scheduler.
// Holds bank geometry, the unity coefficient, the coefficient and band
// enumerations, the scheduler state type and the bank-index helper.
package eq_pkg;

    localparam int NUM_COEF       = 15;
    localparam int COEFS_PER_BAND = 5;

    typedef logic signed [15:0] coef_t;

    // Q2.14 unity gain. With b0 = 1 and all other taps at 0, a biquad is a wire.
    localparam coef_t COEF_UNITY = 16'sh4000;

    typedef enum logic [2:0] {B0, B1, B2, A1, A2} coef_sel_e;
    typedef enum logic [1:0] {LOW, MID, HIGH} band_e;
    typedef enum logic {IDLE, PENDING} sched_state_e;

    // Flat bank index of one coefficient: band*5 + coef.
    function automatic logic [3:0] coef_idx(band_e band, coef_sel_e sel);
        return 4'(int'(band) * COEFS_PER_BAND + int'(sel));
    endfunction

    // Reset value of one bank entry: b0 of every band is unity, the rest 0.
    function automatic coef_t coef_default(int idx);
        return ((idx % COEFS_PER_BAND) == 0) ? COEF_UNITY : coef_t'(0);
    endfunction

endpackage

// File: rtl/lr_edge_detect.sv
// Sample-boundary detector for the left/right select.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   l_r_clk    : left/right select (any edge starts a new sample)
//   edge_det   : high in any cycle where l_r_clk differs from last cycle's value
module lr_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic l_r_clk,
    output logic edge_det
);

    logic l_r_clk_prev_q;
    logic l_r_clk_prev_d;

    always_comb begin
        l_r_clk_prev_d = l_r_clk;
        // Rising and falling edges both mark a new sample.
        edge_det       = (l_r_clk != l_r_clk_prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_r_clk_prev_q <= 1'b0;
        end else begin
            l_r_clk_prev_q <= l_r_clk_prev_d;
        end
    end

endmodule

// File: rtl/eq_coeff_scheduler.sv
// Coefficient controller for the cascaded three-band biquad equalizer.
// MCU writes fill a shadow bank; a commit arms a swap that copies the whole
// shadow bank into the active bank on the next l_r_clk edge, so a filter never
// sees a sample with mixed old/new coefficients.
// Optional feature macro: EQ_COEFF_READBACK_EN adds rd_addr/rd_data, a
// registered (1-cycle) readback of the active bank.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   l_r_clk               : left/right select, each edge is a sample boundary
//   wr_valid/wr_ready     : write handshake, wr_addr = band*5 + coef, wr_data Q2.14
//   commit                : one-cycle swap request
//   pending               : swap armed, waiting for an l_r_clk edge
//   swap_done             : one-cycle pulse the cycle after the active bank updates
//   addr_err              : one-cycle pulse after a write to an address >= 15 is accepted
//   low_*/mid_*/high_*    : active-bank coefficients
//   rd_addr/rd_data       : (EQ_COEFF_READBACK_EN only) active-bank readback
module eq_coeff_scheduler
    import eq_pkg::*;
#(
    parameter int NUM_COEF = 15,
    parameter int COEF_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l_r_clk,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              commit,
    output logic              pending,
    output logic              swap_done,
    output logic              addr_err,
    output logic [COEF_W-1:0] low_b0,
    output logic [COEF_W-1:0] low_b1,
    output logic [COEF_W-1:0] low_b2,
    output logic [COEF_W-1:0] low_a1,
    output logic [COEF_W-1:0] low_a2,
    output logic [COEF_W-1:0] mid_b0,
    output logic [COEF_W-1:0] mid_b1,
    output logic [COEF_W-1:0] mid_b2,
    output logic [COEF_W-1:0] mid_a1,
    output logic [COEF_W-1:0] mid_a2,
    output logic [COEF_W-1:0] high_b0,
    output logic [COEF_W-1:0] high_b1,
    output logic [COEF_W-1:0] high_b2,
    output logic [COEF_W-1:0] high_a1,
    output logic [COEF_W-1:0] high_a2
`ifdef EQ_COEFF_READBACK_EN
    ,
    input  logic [3:0]        rd_addr,
    output logic [COEF_W-1:0] rd_data
`endif
);

    sched_state_e state_q, state_d;
    logic signed [COEF_W-1:0] shadow_q [NUM_COEF];
    logic signed [COEF_W-1:0] shadow_d [NUM_COEF];
    logic signed [COEF_W-1:0] active_q [NUM_COEF];
    logic signed [COEF_W-1:0] active_d [NUM_COEF];
    logic swap_done_q, swap_done_d;
    logic addr_err_q,  addr_err_d;
    logic edge_det;

    lr_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .l_r_clk  (l_r_clk),
        .edge_det (edge_det)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        swap_done_d = 1'b0;
        addr_err_d  = 1'b0;
        wr_ready    = (state_q == IDLE);
        pending     = (state_q == PENDING);
        case (state_q)
            IDLE: begin
                // A write and a commit in the same cycle both take effect: the
                // write lands in shadow now and the later swap copies it.
                if (wr_valid) begin
                    if (wr_addr < 4'(NUM_COEF)) begin
                        shadow_d[wr_addr] = wr_data;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                // An edge in the commit cycle is not used; the swap waits for
                // the next boundary so it always starts on a fresh sample.
                if (commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (edge_det) begin
                    active_d    = shadow_q;
                    state_d     = IDLE;
                    swap_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            swap_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow_q[i] <= coef_default(i);
                active_q[i] <= coef_default(i);
            end
        end else begin
            state_q     <= state_d;
            swap_done_q <= swap_done_d;
            addr_err_q  <= addr_err_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    assign swap_done = swap_done_q;
    assign addr_err  = addr_err_q;

    assign low_b0  = active_q[coef_idx(LOW,  B0)];
    assign low_b1  = active_q[coef_idx(LOW,  B1)];
    assign low_b2  = active_q[coef_idx(LOW,  B2)];
    assign low_a1  = active_q[coef_idx(LOW,  A1)];
    assign low_a2  = active_q[coef_idx(LOW,  A2)];
    assign mid_b0  = active_q[coef_idx(MID,  B0)];
    assign mid_b1  = active_q[coef_idx(MID,  B1)];
    assign mid_b2  = active_q[coef_idx(MID,  B2)];
    assign mid_a1  = active_q[coef_idx(MID,  A1)];
    assign mid_a2  = active_q[coef_idx(MID,  A2)];
    assign high_b0 = active_q[coef_idx(HIGH, B0)];
    assign high_b1 = active_q[coef_idx(HIGH, B1)];
    assign high_b2 = active_q[coef_idx(HIGH, B2)];
    assign high_a1 = active_q[coef_idx(HIGH, A1)];
    assign high_a2 = active_q[coef_idx(HIGH, A2)];

`ifdef EQ_COEFF_READBACK_EN
    logic [COEF_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (rd_addr < 4'(NUM_COEF)) begin
            rd_data_d = active_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
